// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues request-to-send,
// shifts one command byte on device clocks and checks the device acknowledge.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int SETUP_CYCLES   = 50,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_INHIBIT   = 3'd1;
   localparam logic [2:0] S_SETUP     = 3'd2;
   localparam logic [2:0] S_SEND      = 3'd3;
   localparam logic [2:0] S_WAIT_IDLE = 3'd4;

   logic [SYNC_STAGES-1:0] clk_sync;
   logic [SYNC_STAGES-1:0] data_sync;
   logic                   clk_s;
   logic                   data_s;
   logic                   clk_prev;
   logic                   fall;
   logic [2:0]             state;
   logic [CNT_W-1:0]       cnt;
   logic [3:0]             bitcnt;
   logic [7:0]             sh;
   logic                   par;
   logic                   data_oe_r;
   logic                   ack_bad;
   logic                   tmo_hit;
   logic                   idle_ok;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_W'(CNT_MAX)) ? v : v + 1'b1;
   endfunction

   // Synchronizers idle high so a reset never manufactures a falling edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clk_sync  <= '1;
         data_sync <= '1;
         clk_prev  <= 1'b1;
      end else begin
         clk_sync[0]  <= ps2_clk_in;
         data_sync[0] <= ps2_data_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            clk_sync[i]  <= clk_sync[i-1];
            data_sync[i] <= data_sync[i-1];
         end
         clk_prev <= clk_s;
      end
   end

   assign clk_s  = clk_sync[SYNC_STAGES-1];
   assign data_s = data_sync[SYNC_STAGES-1];
   assign fall   = clk_prev & ~clk_s;

   assign tmo_hit = ((state == S_SEND) || (state == S_WAIT_IDLE)) &&
                    (cnt == CNT_W'(TIMEOUT_CYCLES));
   assign idle_ok = (state == S_WAIT_IDLE) && clk_s && data_s && !tmo_hit;

   always_ff @(posedge clk) begin
      if (state == S_IDLE && tx_valid) begin
         sh  <= tx_data;
         par <= ~^tx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         bitcnt    <= '0;
         data_oe_r <= 1'b0;
         ack_bad   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (tx_valid) begin
                  cnt    <= '0;
                  bitcnt <= '0;
                  state  <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                  cnt   <= '0;
                  state <= S_SETUP;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            S_SETUP: begin
               if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
                  cnt       <= '0;
                  bitcnt    <= '0;
                  data_oe_r <= 1'b1;
                  state     <= S_SEND;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            S_SEND: begin
               // Timeout wins over a falling edge arriving in the same cycle.
               if (tmo_hit) begin
                  cnt       <= '0;
                  data_oe_r <= 1'b0;
                  state     <= S_IDLE;
               end else if (fall) begin
                  cnt    <= '0;
                  bitcnt <= bitcnt + 4'd1;
                  if (bitcnt < 4'd8) begin
                     data_oe_r <= ~sh[bitcnt[2:0]];
                  end else if (bitcnt == 4'd8) begin
                     data_oe_r <= ~par;
                  end else if (bitcnt == 4'd9) begin
                     data_oe_r <= 1'b0;
                  end else begin
                     data_oe_r <= 1'b0;
                     ack_bad   <= data_s;
                     state     <= S_WAIT_IDLE;
                  end
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            S_WAIT_IDLE: begin
               if (tmo_hit || (clk_s && data_s)) begin
                  cnt   <= '0;
                  state <= S_IDLE;
               end else begin
                  cnt <= sat_inc(cnt);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign tx_ready    = (state == S_IDLE);
   assign busy        = (state != S_IDLE);
   assign ps2_clk_oe  = (state == S_INHIBIT) || (state == S_SETUP);
   assign ps2_data_oe = (state == S_SETUP) || ((state == S_SEND) && data_oe_r && !tmo_hit);
   assign done        = idle_ok && !ack_bad;
   assign ack_err     = idle_ok && ack_bad;
   assign timeout     = tmo_hit;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter. Sends one command byte to the keyboard, e.g. 0xED (set LEDs), 0xF4 (enable), 0xFF (reset).
- Sits beside the PS/2 keyboard receiver on the same two open-drain lines.
- Performs the full host request sequence:
  - inhibits the clock, then issues the request-to-send;
  - shifts 8 data bits LSB first, odd parity and stop on device-generated clocks;
  - checks the device acknowledge bit.
- `busy` lets the receiver path ignore frames clocked during a transmission.

Parameters:
- INHIBIT_CYCLES, 5000: cycles `ps2_clk` is held low before the request (100 us at 50 MHz).
- SETUP_CYCLES, 50: cycles with clock still low and data low, before the clock is released (1 us).
- TIMEOUT_CYCLES, 1000000: maximum cycles between device falling edges, or while waiting for idle (20 ms).
- SYNC_STAGES, 2: synchronizer depth on `ps2_clk_in` and `ps2_data_in`.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- tx_data  in  8  command byte.
- tx_valid  in  1  request to send `tx_data`.
- tx_ready  out  1  high only in IDLE; a byte is accepted on a cycle with `tx_valid && tx_ready`.
- ps2_clk_in  in  1  PS/2 clock pin level.
- ps2_data_in  in  1  PS/2 data pin level.
- ps2_clk_oe  out  1  1 = drive `ps2_clk` low; 0 = release (pull-up).
- ps2_data_oe  out  1  1 = drive `ps2_data` low; 0 = release.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: frame sent and ACK received.
- ack_err  out  1  one-cycle pulse: frame sent but ACK bit read as 1.
- timeout  out  1  one-cycle pulse: device stopped clocking, or lines did not return to idle.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE;
  - `ps2_clk_oe` = `ps2_data_oe` = 0 (both lines released, even mid-frame);
  - `tx_ready` = 1; `busy`, `done`, `ack_err`, `timeout` = 0;
  - all counters = 0.
- Inputs pass through SYNC_STAGES flops. A falling edge is detected when the synchronized clock is 1 in the previous cycle and 0 now.
- The transmitter acts on a falling edge no later than SYNC_STAGES+1 cycles after the pin falls.
- Accept: on `tx_valid && tx_ready`:
  - latch `sh = tx_data` and `par = ~^tx_data` (odd parity);
  - enter INHIBIT the next cycle;
  - `tx_valid` is ignored in all other states.
- INHIBIT: `clk_oe` = 1, `data_oe` = 0. Stay exactly INHIBIT_CYCLES cycles, then go to SETUP.
- SETUP: `clk_oe` = 1, `data_oe` = 1 (start bit). Stay exactly SETUP_CYCLES cycles, then go to SEND with `bitcnt` = 0.
- SEND: `clk_oe` = 0. On each detected falling edge, `bitcnt` increments and the data line is set as follows:
  - edges 1..8: `data_oe` = ~sh[bitcnt-1] (data bits, LSB first);
  - edge 9: `data_oe` = ~par;
  - edge 10: `data_oe` = 0 (stop bit, line released);
  - edge 11: sample synchronized `ps2_data_in`:
    - 0 → go to WAIT_IDLE with a pending ok result;
    - 1 → go to WAIT_IDLE with a pending error result.
- WAIT_IDLE: both outputs released. When the synchronized clock and data are both 1:
  - pulse `done` (ok) or `ack_err` (error);
  - return to IDLE on the same cycle.
- Timeout:
  - Counter clears on entry to SEND and on every falling edge; in WAIT_IDLE it counts from entry.
  - On reaching TIMEOUT_CYCLES in SEND or WAIT_IDLE: release both lines, pulse `timeout`, go to IDLE.
  - `timeout` takes priority over a falling edge in the same cycle.
- Exactly one of `done`, `ack_err`, `timeout` pulses per accepted byte.
- `tx_ready` is reasserted on the cycle after the pulse.
- Device pulling clock low during INHIBIT or SETUP is ignored; no edges are counted before SEND.
- Widths:
  - `bitcnt` is 4 bits and never exceeds 11;
  - the INHIBIT/SETUP/timeout counter is wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES) and saturates, never wraps.

Test Plan:
1. Device BFM (clock period 80 us, ACK driven) plus `tx_data` = 0xED → `clk_oe` high for exactly 5000 cycles, then 50 cycles with both oe high; BFM captures data 0xED, parity 1, stop 1; `done` pulses once; `ack_err` = `timeout` = 0.
2. `tx_data` = 0xF4 and 0x01 → BFM reads parity 0 for both; 0x00 and 0xFF → parity 1; all four end with `done`.
3. BFM leaves data high at the ACK clock → `ack_err` pulses once; `done` = 0; lines released; `tx_ready` = 1 the cycle after.
4. BFM stops after 5 clocks → `timeout` pulses exactly TIMEOUT_CYCLES cycles after the 5th falling edge; both oe = 0; IDLE.
5. `rst` asserted mid-SEND (after edge 4, while `data_oe` = 1) → `data_oe` = `clk_oe` = 0 in the same cycle, without waiting for a clock edge; `busy` = 0; a new 0xFF request after deassert completes with `done`.
6. `tx_valid` held high through a whole transfer with `tx_data` changed mid-frame → only the originally latched byte is transmitted; the next byte is accepted only after `done`.
